// File: rtl/scpad_dram_write_drain.sv
// Scratchpad DRAM write drain: splits one latched line write into beat-wide
// DRAM write beats and tracks un-acked bursts.
module scpad_dram_write_drain #(
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES      = 128,
  parameter int unsigned BEAT_BYTES      = 16,
  parameter int unsigned COL_IDX_WIDTH   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic                                   req_valid,
  input  logic [DRAM_ADDR_WIDTH-1:0]             req_addr,
  input  logic [COL_IDX_WIDTH-1:0]               req_num_bytes,
  input  logic [LINE_BYTES*8-1:0]                req_wdata,
  output logic                                   req_accepted,
  output logic                                   dram_wvalid,
  input  logic                                   dram_wready,
  output logic [DRAM_ADDR_WIDTH-1:0]             dram_waddr,
  output logic [BEAT_BYTES*8-1:0]                dram_wdata,
  output logic [BEAT_BYTES-1:0]                  dram_wstrb,
  output logic                                   dram_wlast,
  input  logic                                   dram_bvalid,
  output logic                                   dram_bready,
  output logic                                   wr_complete,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   busy,
  output logic                                   err_unexpected_ack
);

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned BEAT_W = BEAT_BYTES * 8;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                     state;
  logic [LINE_W-1:0]          line_q;     // beats not yet presented, next beat in LSBs
  logic [COL_IDX_WIDTH-1:0]   rem_q;      // bytes remaining from the current beat on
  logic                       bready_q;

  logic [COL_IDX_WIDTH-1:0]   req_len_c;
  logic [COL_IDX_WIDTH-1:0]   rem_next_c;
  logic                       room_c;
  logic                       beat_fire_c;
  logic                       last_fire_c;
  logic                       ack_c;
  logic                       spurious_c;

  // Byte enables for a beat with `rem` valid bytes from its first byte onward.
  function automatic logic [BEAT_BYTES-1:0] strb_for(input logic [COL_IDX_WIDTH-1:0] rem);
    logic [BEAT_BYTES-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
      s[i] = (COL_IDX_WIDTH'(i) < rem);
    end
    return s;
  endfunction

  // Effective request length: zero or oversize means a full line.
  always_comb begin
    req_len_c = req_num_bytes;
    if ((req_num_bytes == '0) || (req_num_bytes > COL_IDX_WIDTH'(LINE_BYTES))) begin
      req_len_c = COL_IDX_WIDTH'(LINE_BYTES);
    end
  end

  assign rem_next_c   = rem_q - COL_IDX_WIDTH'(BEAT_BYTES);
  assign room_c       = (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign req_accepted = (state == IDLE) && req_valid && room_c;
  assign beat_fire_c  = dram_wvalid && dram_wready;
  assign last_fire_c  = beat_fire_c && dram_wlast;
  assign ack_c        = dram_bvalid && dram_bready && (outstanding != '0);
  assign spurious_c   = dram_bvalid && dram_bready && (outstanding == '0);
  assign dram_bready  = bready_q;
  assign busy         = (state != IDLE) || (outstanding != '0);

  // Request latch and beat sequencing; beat outputs advance only on handshake.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      line_q      <= '0;
      rem_q       <= '0;
      dram_wvalid <= 1'b0;
      dram_waddr  <= '0;
      dram_wdata  <= '0;
      dram_wstrb  <= '0;
      dram_wlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_accepted) begin
            state       <= SEND;
            dram_wvalid <= 1'b1;
            dram_waddr  <= req_addr;
            dram_wdata  <= req_wdata[BEAT_W-1:0];
            dram_wstrb  <= strb_for(req_len_c);
            dram_wlast  <= (req_len_c <= COL_IDX_WIDTH'(BEAT_BYTES));
            rem_q       <= req_len_c;
            line_q      <= req_wdata >> BEAT_W;
          end
        end
        SEND: begin
          if (beat_fire_c) begin
            if (dram_wlast) begin
              state       <= IDLE;
              dram_wvalid <= 1'b0;
              dram_wlast  <= 1'b0;
              dram_wstrb  <= '0;
            end else begin
              dram_waddr <= dram_waddr + DRAM_ADDR_WIDTH'(BEAT_BYTES);
              dram_wdata <= line_q[BEAT_W-1:0];
              line_q     <= line_q >> BEAT_W;
              dram_wstrb <= strb_for(rem_next_c);
              dram_wlast <= (rem_next_c <= COL_IDX_WIDTH'(BEAT_BYTES));
              rem_q      <= rem_next_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding-burst accounting, completion pulse and spurious-ack flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bready_q           <= 1'b0;
      outstanding        <= '0;
      wr_complete        <= 1'b0;
      err_unexpected_ack <= 1'b0;
    end else begin
      bready_q    <= 1'b1;
      wr_complete <= ack_c;
      if (spurious_c) begin
        err_unexpected_ack <= 1'b1;
      end
      case ({last_fire_c, ack_c})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_scpad_dram_write_drain.sv
// Bench for scpad_dram_write_drain: expected beats are queued when a request
// is accepted and popped as the DUT hands beats to the DRAM channel.
module tb_scpad_dram_write_drain;

  localparam int unsigned AW = 32;
  localparam int unsigned LB = 128;
  localparam int unsigned BB = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned MO = 4;
  localparam int unsigned OW = $clog2(MO + 1);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [BB*8-1:0] data;
    logic [BB-1:0]   strb;
    logic            last;
  } beat_t;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            req_valid = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [CW-1:0]   req_num_bytes = '0;
  logic [LB*8-1:0] req_wdata = '0;
  logic            req_accepted;
  logic            dram_wvalid;
  logic            dram_wready = 1'b0;
  logic [AW-1:0]   dram_waddr;
  logic [BB*8-1:0] dram_wdata;
  logic [BB-1:0]   dram_wstrb;
  logic            dram_wlast;
  logic            dram_bvalid = 1'b0;
  logic            dram_bready;
  logic            wr_complete;
  logic [OW-1:0]   outstanding;
  logic            busy;
  logic            err_unexpected_ack;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  always #5 CLK = ~CLK;

  scpad_dram_write_drain #(
    .DRAM_ADDR_WIDTH(AW), .LINE_BYTES(LB), .BEAT_BYTES(BB),
    .COL_IDX_WIDTH(CW), .MAX_OUTSTANDING(MO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_addr(req_addr), .req_num_bytes(req_num_bytes),
    .req_wdata(req_wdata), .req_accepted(req_accepted),
    .dram_wvalid(dram_wvalid), .dram_wready(dram_wready), .dram_waddr(dram_waddr),
    .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb), .dram_wlast(dram_wlast),
    .dram_bvalid(dram_bvalid), .dram_bready(dram_bready), .wr_complete(wr_complete),
    .outstanding(outstanding), .busy(busy), .err_unexpected_ack(err_unexpected_ack)
  );

  // Advance to just after the next rising edge (the drive point).
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [LB*8-1:0] rand_line();
    logic [LB*8-1:0] v;
    for (int i = 0; i < int'(LB / 4); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: queue every beat the request should produce.
  task automatic push_req(input logic [AW-1:0] a, input logic [CW-1:0] nb, input logic [LB*8-1:0] line);
    int len;
    int nbeats;
    beat_t b;
    len = ((nb == 0) || (int'(nb) > int'(LB))) ? int'(LB) : int'(nb);
    nbeats = (len + int'(BB) - 1) / int'(BB);
    for (int k = 0; k < nbeats; k++) begin
      b.addr = a + AW'(k * int'(BB));
      b.data = line[k*int'(BB)*8 +: BB*8];
      for (int i = 0; i < int'(BB); i++) b.strb[i] = ((k * int'(BB) + i) < len);
      b.last = (k == nbeats - 1);
      exp_q.push_back(b);
    end
  endtask

  // Present a request; on acceptance queue its beats and scramble req_* inputs.
  task automatic issue(input logic [AW-1:0] a, input logic [CW-1:0] nb, input logic [LB*8-1:0] line,
                       input int budget, output bit ok);
    req_valid = 1'b1;
    req_addr = a;
    req_num_bytes = nb;
    req_wdata = line;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      #1;
      if (req_accepted === 1'b1) begin
        ok = 1'b1;
        push_req(a, nb, line);
      end
      cyc();
    end
    if (ok) begin
      req_valid = 1'b0;
      req_addr = $urandom();
      req_num_bytes = CW'($urandom());
      req_wdata = rand_line();
    end
  endtask

  // Run the write channel, checking each presented beat against the scoreboard.
  task automatic drain(input string tag, input int stall_beat, input int stall_len, input int stop_after,
                       input bit ack_on_last, output int vcycles);
    int popped;
    int stalled;
    bit done;
    beat_t got;
    beat_t e;
    popped = 0;
    stalled = 0;
    done = 1'b0;
    vcycles = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      dram_wready = !((popped == stall_beat) && (stalled < stall_len));
      dram_bvalid = ack_on_last && dram_wready && (exp_q.size() > 0) && exp_q[0].last;
      #1;
      got = {dram_waddr, dram_wdata, dram_wstrb, dram_wlast};
      if (dram_wvalid === 1'b1) begin
        vcycles++;
        n_cmp++;
        if (req_accepted !== 1'b0) begin
          n_mis++;
          $display("FAIL %s accept_during_burst: req_accepted=%b required 0", tag, req_accepted);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL %s unexpected_beat: addr=%h with empty scoreboard", tag, dram_waddr);
          done = 1'b1;
        end else begin
          e = exp_q[0];
          if (got !== e) begin
            n_mis++;
            $display("FAIL %s beat%0d: addr=%h strb=%h last=%b data=%h required addr=%h strb=%h last=%b data=%h",
                     tag, popped, got.addr, got.strb, got.last, got.data, e.addr, e.strb, e.last, e.data);
          end
          if (dram_wready) begin
            void'(exp_q.pop_front());
            popped++;
            if (e.last || (popped == stop_after)) done = 1'b1;
          end else begin
            stalled++;
          end
        end
      end
      cyc();
    end
    dram_wready = 1'b0;
    dram_bvalid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_mis++;
      $display("FAIL %s timeout: burst incomplete after 60 cycles, popped=%0d", tag, popped);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #12;
    n_cmp++;
    if ({req_accepted, dram_wvalid, dram_wlast, dram_bready, wr_complete, busy, err_unexpected_ack} !== 7'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: acc/wv/wl/br/wc/busy/err=%b required 0000000",
               {req_accepted, dram_wvalid, dram_wlast, dram_bready, wr_complete, busy, err_unexpected_ack});
    end
    n_cmp++;
    if ({dram_waddr, dram_wdata, dram_wstrb, outstanding} !== '0) begin
      n_mis++;
      $display("FAIL reset_data: addr=%h data=%h strb=%h outst=%0d required all 0",
               dram_waddr, dram_wdata, dram_wstrb, outstanding);
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc();
    n_cmp++;
    if ({dram_bready, busy} !== 2'b10) begin
      n_mis++;
      $display("FAIL reset_release: bready/busy=%b required 10", {dram_bready, busy});
    end
  endtask

  task automatic test_full_line();
    bit ok;
    int vc;
    issue(32'h1000, 8'd0, rand_line(), 4, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_mis++; $display("FAIL full_accept: accepted=%b required 1", ok); end
    drain("full", -1, 0, 0, 1'b0, vc);
    n_cmp++;
    if (vc != 8) begin n_mis++; $display("FAIL full_cycles: %0d required 8", vc); end
    n_cmp++;
    if ({outstanding, busy, dram_wvalid} !== {OW'(1), 2'b10}) begin
      n_mis++;
      $display("FAIL full_outst: outst=%0d busy=%b wvalid=%b required 1 1 0", outstanding, busy, dram_wvalid);
    end
    dram_bvalid = 1'b1;
    cyc();
    dram_bvalid = 1'b0;
    n_cmp++;
    if ({wr_complete, outstanding, busy} !== {1'b1, OW'(0), 1'b0}) begin
      n_mis++;
      $display("FAIL full_ack: wc=%b outst=%0d busy=%b required 1 0 0", wr_complete, outstanding, busy);
    end
    cyc();
    n_cmp++;
    if (wr_complete !== 1'b0) begin n_mis++; $display("FAIL full_wc_pulse: wc=%b required 0", wr_complete); end
  endtask

  task automatic test_partial();
    bit ok;
    int vc;
    issue(32'h2000, 8'd20, rand_line(), 4, ok);
    drain("part20", -1, 0, 0, 1'b0, vc);
    n_cmp++;
    if (vc != 2) begin n_mis++; $display("FAIL part20_cycles: %0d required 2", vc); end
    issue(32'h3000, 8'd200, rand_line(), 4, ok);
    drain("part200", -1, 0, 0, 1'b0, vc);
    n_cmp++;
    if (vc != 8) begin n_mis++; $display("FAIL part200_cycles: %0d required 8", vc); end
    n_cmp++;
    if (outstanding !== OW'(2)) begin n_mis++; $display("FAIL part_outst: %0d required 2", outstanding); end
    dram_bvalid = 1'b1;
    cyc();
    n_cmp++;
    if ({wr_complete, outstanding} !== {1'b1, OW'(1)}) begin
      n_mis++;
      $display("FAIL part_ack1: wc=%b outst=%0d required 1 1", wr_complete, outstanding);
    end
    cyc();
    dram_bvalid = 1'b0;
    n_cmp++;
    if ({wr_complete, outstanding} !== {1'b1, OW'(0)}) begin
      n_mis++;
      $display("FAIL part_ack2: wc=%b outst=%0d required 1 0", wr_complete, outstanding);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    bit ok;
    int vc;
    issue(32'h4000, 8'd0, rand_line(), 4, ok);
    drain("bp", 2, 3, 0, 1'b0, vc);
    n_cmp++;
    if (vc != 11) begin n_mis++; $display("FAIL bp_cycles: %0d required 11", vc); end
    dram_bvalid = 1'b1;
    cyc();
    dram_bvalid = 1'b0;
    n_cmp++;
    if (outstanding !== OW'(0)) begin n_mis++; $display("FAIL bp_outst: %0d required 0", outstanding); end
  endtask

  task automatic test_outstanding_limit();
    bit ok;
    int vc;
    int cnt;
    logic [LB*8-1:0] line5;
    for (int r = 0; r < 4; r++) begin
      issue(AW'(32'h8000 + r * 32'h100), 8'd16, rand_line(), (r == 0) ? 4 : 1, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_mis++; $display("FAIL lim_accept%0d: accepted=%b required 1", r, ok); end
      drain("lim", -1, 0, 0, 1'b0, vc);
    end
    n_cmp++;
    if (outstanding !== OW'(4)) begin n_mis++; $display("FAIL lim_outst4: %0d required 4", outstanding); end
    line5 = rand_line();
    issue(32'h8400, 8'd16, line5, 5, ok);
    n_cmp++;
    if ({ok, busy} !== 2'b01) begin
      n_mis++;
      $display("FAIL lim_stall: accepted=%b busy=%b required 0 1", ok, busy);
    end
    dram_bvalid = 1'b1;
    #1;
    n_cmp++;
    if (req_accepted !== 1'b0) begin n_mis++; $display("FAIL lim_ack_cycle: req_accepted=%b required 0", req_accepted); end
    cyc();
    dram_bvalid = 1'b0;
    #1;
    n_cmp++;
    if ({req_accepted, wr_complete} !== 2'b11) begin
      n_mis++;
      $display("FAIL lim_reopen: acc/wc=%b required 11", {req_accepted, wr_complete});
    end
    push_req(32'h8400, 8'd16, line5);
    cyc();
    req_valid = 1'b0;
    drain("lim5", -1, 0, 0, 1'b0, vc);
    n_cmp++;
    if ({outstanding, err_unexpected_ack} !== {OW'(4), 1'b0}) begin
      n_mis++;
      $display("FAIL lim_outst5: outst=%0d err=%b required 4 0", outstanding, err_unexpected_ack);
    end
    dram_bvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (wr_complete === 1'b1) cnt++;
    end
    dram_bvalid = 1'b0;
    n_cmp++;
    if (cnt != 4) begin n_mis++; $display("FAIL lim_wc_count: %0d required 4", cnt); end
    cyc();
    n_cmp++;
    if ({outstanding, err_unexpected_ack, wr_complete} !== {OW'(0), 2'b00}) begin
      n_mis++;
      $display("FAIL lim_drained: outst=%0d err=%b wc=%b required 0 0 0", outstanding, err_unexpected_ack, wr_complete);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int vc;
    issue(32'h6000, 8'd8, rand_line(), 4, ok);
    drain("sim1", -1, 0, 0, 1'b0, vc);
    issue(32'h6100, 8'd32, rand_line(), 4, ok);
    drain("sim2", -1, 0, 0, 1'b1, vc);
    n_cmp++;
    if (vc != 2) begin n_mis++; $display("FAIL sim_cycles: %0d required 2", vc); end
    n_cmp++;
    if ({wr_complete, outstanding} !== {1'b1, OW'(1)}) begin
      n_mis++;
      $display("FAIL sim_same_cycle: wc=%b outst=%0d required 1 1", wr_complete, outstanding);
    end
    dram_bvalid = 1'b1;
    cyc();
    dram_bvalid = 1'b0;
    n_cmp++;
    if ({wr_complete, outstanding, err_unexpected_ack} !== {1'b1, OW'(0), 1'b0}) begin
      n_mis++;
      $display("FAIL sim_last_ack: wc=%b outst=%0d err=%b required 1 0 0", wr_complete, outstanding, err_unexpected_ack);
    end
    dram_bvalid = 1'b1;
    cyc();
    dram_bvalid = 1'b0;
    n_cmp++;
    if ({wr_complete, outstanding, err_unexpected_ack} !== {1'b0, OW'(0), 1'b1}) begin
      n_mis++;
      $display("FAIL sim_spurious: wc=%b outst=%0d err=%b required 0 0 1", wr_complete, outstanding, err_unexpected_ack);
    end
    cyc();
    n_cmp++;
    if (err_unexpected_ack !== 1'b1) begin n_mis++; $display("FAIL sim_sticky: err=%b required 1", err_unexpected_ack); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int vc;
    issue(32'h7000, 8'd4, rand_line(), 4, ok);
    drain("rm0", -1, 0, 0, 1'b0, vc);
    issue(32'h7100, 8'd0, rand_line(), 4, ok);
    drain("rm1", -1, 0, 3, 1'b0, vc);
    n_cmp++;
    if ({dram_wvalid, outstanding} !== {1'b1, OW'(1)}) begin
      n_mis++;
      $display("FAIL rm_pre: wvalid=%b outst=%0d required 1 1", dram_wvalid, outstanding);
    end
    #2;
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({req_accepted, dram_wvalid, dram_wlast, dram_bready, wr_complete, busy, err_unexpected_ack} !== 7'b0) begin
      n_mis++;
      $display("FAIL rm_ctrl: acc/wv/wl/br/wc/busy/err=%b required 0000000",
               {req_accepted, dram_wvalid, dram_wlast, dram_bready, wr_complete, busy, err_unexpected_ack});
    end
    n_cmp++;
    if ({dram_waddr, dram_wdata, dram_wstrb, outstanding} !== '0) begin
      n_mis++;
      $display("FAIL rm_data: addr=%h data=%h strb=%h outst=%0d required all 0",
               dram_waddr, dram_wdata, dram_wstrb, outstanding);
    end
    exp_q.delete();
    cyc();
    nRST = 1'b1;
    cyc();
    issue(32'h5000, 8'd48, rand_line(), 4, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_mis++; $display("FAIL rm_accept: accepted=%b required 1", ok); end
    drain("rm2", -1, 0, 0, 1'b0, vc);
    n_cmp++;
    if ({vc, outstanding} !== {32'd3, OW'(1)}) begin
      n_mis++;
      $display("FAIL rm_after: cycles=%0d outst=%0d required 3 1", vc, outstanding);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_line();
    test_partial();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/scpad_dram_write_drain.md
# scpad_dram_write_drain

Scratchpad backend block on the DRAM side of the write-request queue. It consumes one latched write request at a time: a DRAM address, a byte count and one full scratchpad line of data. It splits the request into BEAT_BYTES-wide write beats on a valid/ready DRAM write channel, and tracks up to MAX_OUTSTANDING bursts awaiting DRAM write acks. It returns the request-accepted pulse to the queue and a per-burst completion pulse to the backend.

## Interface
Clock is `CLK`. Reset is `nRST`, asynchronous and active-low.

Parameters:
- DRAM_ADDR_WIDTH, 32, DRAM byte address width
- LINE_BYTES, 128, scratchpad line size in bytes; `req_wdata` is LINE_BYTES*8 bits
- BEAT_BYTES, 16, DRAM write beat size; LINE_BYTES must be a multiple of it
- COL_IDX_WIDTH, 8, `req_num_bytes` width; must be ≥ clog2(LINE_BYTES+1)
- MAX_OUTSTANDING, 4, maximum un-acked bursts

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  write-queue head holds a valid request
- req_addr  in  DRAM_ADDR_WIDTH  burst start byte address
- req_num_bytes  in  COL_IDX_WIDTH  valid bytes in the line, starting at byte 0 (LSB)
- req_wdata  in  LINE_BYTES*8  line data, byte 0 in bits [7:0]
- req_accepted  out  1  one-cycle pulse: request latched, queue may pop
- dram_wvalid  out  1  beat valid
- dram_wready  in  1  DRAM accepts beat
- dram_waddr  out  DRAM_ADDR_WIDTH  beat byte address
- dram_wdata  out  BEAT_BYTES*8  beat data
- dram_wstrb  out  BEAT_BYTES  byte enables
- dram_wlast  out  1  final beat of burst
- dram_bvalid  in  1  one burst acked by DRAM
- dram_bready  out  1  ack accept
- wr_complete  out  1  one-cycle pulse per acked burst
- outstanding  out  clog2(MAX_OUTSTANDING+1)  un-acked burst count
- busy  out  1  state≠IDLE or outstanding≠0
- err_unexpected_ack  out  1  sticky: ack received with outstanding==0

## Operation
- Effective length: L = LINE_BYTES when `req_num_bytes`==0 or `req_num_bytes`>LINE_BYTES, otherwise L = `req_num_bytes`.
- Beat count: N = ceil(L/BEAT_BYTES), in the range 1..LINE_BYTES/BEAT_BYTES.
- FSM states: IDLE, SEND.
  - IDLE: when `req_valid` && `outstanding`<MAX_OUTSTANDING, pulse `req_accepted`, latch addr/L/data, clear the beat index k, go to SEND.
  - SEND: drive beat k.
    - `dram_waddr` = addr + k*BEAT_BYTES, with wraparound modulo 2^DRAM_ADDR_WIDTH.
    - `dram_wdata` = line[k*BEAT_BYTES*8 +: BEAT_BYTES*8].
    - `dram_wstrb` bit i = (k*BEAT_BYTES+i < L).
    - `dram_wlast` = (k==N-1).
  - On a `dram_wvalid`&&`dram_wready` handshake, k increments. On the last-beat handshake, `outstanding` increments and the FSM returns to IDLE.
- Low address bits are forwarded unchanged; alignment is the caller's responsibility.
- Ack path:
  - `dram_bready`=1 whenever out of reset.
  - Each `dram_bvalid` with `outstanding`>0 decrements `outstanding` and pulses `wr_complete` the next cycle.
  - With `outstanding`==0, the ack is ignored and `err_unexpected_ack` is set.
- Simultaneous last-beat handshake and ack: `outstanding` is unchanged and `wr_complete` still pulses.
- `req_*` inputs are sampled only in the `req_accepted` cycle; changes after that have no effect.

## Timing
- Reset values: `req_accepted`=0, `dram_wvalid`=0, `dram_waddr`/`dram_wdata`/`dram_wstrb`=0, `dram_wlast`=0, `dram_bready`=0, `wr_complete`=0, `outstanding`=0, `busy`=0, `err_unexpected_ack`=0, FSM=IDLE.
- `req_accepted` is combinational from IDLE, `req_valid` and room. It is high only in the cycle the latch occurs.
- First beat: `dram_wvalid` rises the cycle after `req_accepted`.
- With `dram_wready` held high, an N-beat burst occupies N consecutive cycles. The next `req_accepted` comes no earlier than the cycle after the last beat.
- Under backpressure, all beat outputs hold stable while `dram_wvalid`&&!`dram_wready`. `dram_wvalid` never deasserts before its handshake.
- `wr_complete` is registered: it is high exactly one cycle after each accepted `dram_bvalid`.
- Full: at `outstanding`==MAX_OUTSTANDING, IDLE holds and `req_accepted` stays 0. The first ack reopens acceptance in the following cycle.
- Reset mid-burst: everything returns to reset values immediately; partial beats and pending acks are abandoned.

## Test plan
- Full line: addr 0x1000, num_bytes 0 → `req_accepted` once; 8 beats at 0x1000, 0x1010, …, 0x1070, all strobes 0xFFFF; `dram_wlast` only on 0x1070; `outstanding`=1; ack → `wr_complete` pulse next cycle, `outstanding`=0, `busy`=0.
- Partial: num_bytes 20, addr 0x2000 → 2 beats with strobes 0xFFFF then 0x000F; num_bytes 200 → clamped to 8 beats.
- Backpressure: `dram_wready` low for 3 cycles on beat 2 → addr/data/strobe/last held; total burst is 11 cycles.
- Outstanding limit: 5 back-to-back requests, no acks → 4 accepted and the 5th is stalled; one ack → 5th accepted the cycle after; `err_unexpected_ack` stays 0.
- Simultaneous events and spurious ack: ack on the same cycle as a last beat → `outstanding` unchanged and `wr_complete` pulses; ack with `outstanding`==0 → `err_unexpected_ack`=1, count stays 0.
- Reset mid-burst: assert `nRST` at beat 3 → all outputs go to reset values asynchronously; a new request after release starts cleanly at beat 0.
